// File: rtl/secuenciador_bus_rtc_pkg.sv
// Shared definitions for the RTC bus sequencer: FSM state encoding,
// bus payload struct with its idle levels, and transaction index constants.
package secuenciador_bus_rtc_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_GAP_A = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP_D = 3'd4,
        ST_DONE  = 3'd5
    } estado_e;

    // Transaction order: segundo, minuto, hora
    localparam logic [IDX_W-1:0] IDX_SEG  = 2'd0;
    localparam logic [IDX_W-1:0] IDX_MIN  = 2'd1;
    localparam logic [IDX_W-1:0] IDX_HORA = 2'd2;

    typedef struct packed {
        logic              cs_n;
        logic              rd_n;
        logic              wr_n;
        logic              a_d;
        logic              ad_oe;
        logic [BYTE_W-1:0] ad_out;
    } bus_t;

    localparam bus_t BUS_IDLE = '{
        cs_n:   1'b1,
        rd_n:   1'b1,
        wr_n:   1'b1,
        a_d:    1'b1,
        ad_oe:  1'b0,
        ad_out: 8'h00
    };

endpackage

// File: rtl/secuenciador_bus_rtc_contador_fase.sv
// Phase timer: 8-bit counter with synchronous clear and a registered
// terminal-count flag that is high while the count equals T_FASE-1.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : restart count from 0 at the next edge
//   tc_o       : count == T_FASE-1
module secuenciador_bus_rtc_contador_fase #(
    parameter int unsigned T_FASE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tc_o
);
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(T_FASE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (reset || clr_i) begin
            cnt_d = '0;
        end
    end

    // Flag registered from the next count so it lines up with cnt_q
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        tc_q  <= (cnt_d == CNT_FIN);
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/secuenciador_bus_rtc.sv
// RTC bus sequencer: on Escribe/Lee runs three multiplexed address/data bus
// cycles (segundo, minuto, hora), writing latched bytes or capturing AD_in,
// then pulses T_Esc or T_Lect for one cycle.
//   Escribe, Lee          : request levels (Escribe wins)
//   Dir_*, segundo/minuto/hora : addresses and write bytes, latched at start
//   AD_in                 : read data from RTC
//   AD_out, AD_oe, CS_n, RD_n, WR_n, A_D : bus signals (all registered)
//   lect_*                : captured read bytes
//   T_Esc, T_Lect         : completion pulses
module secuenciador_bus_rtc
    import secuenciador_bus_rtc_pkg::*;
#(
    parameter int unsigned T_FASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Escribe,
    input  logic       Lee,
    input  logic [7:0] Dir_segundo,
    input  logic [7:0] Dir_minuto,
    input  logic [7:0] Dir_hora,
    input  logic [7:0] segundo,
    input  logic [7:0] minuto,
    input  logic [7:0] hora,
    input  logic [7:0] AD_in,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D,
    output logic [7:0] lect_seg,
    output logic [7:0] lect_min,
    output logic [7:0] lect_hora,
    output logic       T_Esc,
    output logic       T_Lect
);
    estado_e                     state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        esc_q, esc_d;
    logic [2:0][BYTE_W-1:0]      dir_q, dir_d;
    logic [2:0][BYTE_W-1:0]      dat_q, dat_d;
    logic [2:0][BYTE_W-1:0]      lect_q, lect_d;
    bus_t                        bus_q, bus_d;
    logic                        t_esc_q, t_esc_d;
    logic                        t_lect_q, t_lect_d;
    logic                        fase_fin;
    logic                        clr_fase_c;

    // Phase counter restarts on every state change
    assign clr_fase_c = (state_d != state_q);

    secuenciador_bus_rtc_contador_fase #(
        .T_FASE (T_FASE)
    ) u_contador_fase (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_fase_c),
        .tc_o  (fase_fin)
    );

    // Next state, latches, and next bus outputs derived from the next state
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        esc_d    = esc_q;
        dir_d    = dir_q;
        dat_d    = dat_q;
        lect_d   = lect_q;
        bus_d    = BUS_IDLE;
        t_esc_d  = 1'b0;
        t_lect_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Escribe || Lee) begin
                    state_d = ST_ADDR;
                    esc_d   = Escribe;
                    idx_d   = IDX_SEG;
                    dir_d   = {Dir_hora, Dir_minuto, Dir_segundo};
                    dat_d   = {hora, minuto, segundo};
                end
            end
            ST_ADDR: begin
                if (fase_fin) state_d = ST_GAP_A;
            end
            ST_GAP_A: state_d = ST_DATA;
            ST_DATA: begin
                if (fase_fin) begin
                    state_d = ST_GAP_D;
                    if (!esc_q) lect_d[idx_q] = AD_in;
                end
            end
            ST_GAP_D: begin
                if (idx_q == IDX_HORA) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_ADDR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = IDX_SEG;
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_ADDR: begin
                bus_d.cs_n   = 1'b0;
                bus_d.a_d    = 1'b0;
                bus_d.wr_n   = 1'b0;
                bus_d.ad_oe  = 1'b1;
                bus_d.ad_out = dir_d[idx_d];
            end
            ST_DATA: begin
                bus_d.cs_n = 1'b0;
                bus_d.a_d  = 1'b1;
                if (esc_d) begin
                    bus_d.wr_n   = 1'b0;
                    bus_d.ad_oe  = 1'b1;
                    bus_d.ad_out = dat_d[idx_d];
                end else begin
                    bus_d.rd_n = 1'b0;
                end
            end
            ST_DONE: begin
                t_esc_d  = esc_d;
                t_lect_d = !esc_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= IDX_SEG;
            esc_q    <= 1'b0;
            dir_q    <= '0;
            dat_q    <= '0;
            lect_q   <= '0;
            bus_q    <= BUS_IDLE;
            t_esc_q  <= 1'b0;
            t_lect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            esc_q    <= esc_d;
            dir_q    <= dir_d;
            dat_q    <= dat_d;
            lect_q   <= lect_d;
            bus_q    <= bus_d;
            t_esc_q  <= t_esc_d;
            t_lect_q <= t_lect_d;
        end
    end

    assign AD_out    = bus_q.ad_out;
    assign AD_oe     = bus_q.ad_oe;
    assign CS_n      = bus_q.cs_n;
    assign RD_n      = bus_q.rd_n;
    assign WR_n      = bus_q.wr_n;
    assign A_D       = bus_q.a_d;
    assign lect_seg  = lect_q[IDX_SEG];
    assign lect_min  = lect_q[IDX_MIN];
    assign lect_hora = lect_q[IDX_HORA];
    assign T_Esc     = t_esc_q;
    assign T_Lect    = t_lect_q;

endmodule

// File: tb/tb_secuenciador_bus_rtc.sv
// Testbench for secuenciador_bus_rtc: directed and randomized sequences
// checked cycle by cycle against a timing model built from phase arithmetic.
module tb_secuenciador_bus_rtc;

    localparam int T  = 4;
    localparam int L  = 2 * T + 2;       // cycles per transaction
    localparam int KD = 3 * L + 1;       // cycle of the completion pulse

    logic       clk = 1'b0;
    logic       reset;
    logic       Escribe, Lee;
    logic [7:0] Dir_segundo, Dir_minuto, Dir_hora;
    logic [7:0] segundo, minuto, hora;
    logic [7:0] AD_in;
    logic [7:0] AD_out;
    logic       AD_oe, CS_n, RD_n, WR_n, A_D;
    logic [7:0] lect_seg, lect_min, lect_hora;
    logic       T_Esc, T_Lect;

    int tests = 0;
    int fails = 0;
    logic [7:0] m_lect [3];

    typedef struct packed {
        logic       cs_n, rd_n, wr_n, a_d, ad_oe;
        logic [7:0] ad_out;
        logic       t_esc, t_lect;
    } exp_t;

    secuenciador_bus_rtc #(.T_FASE(T)) dut (
        .clk(clk), .reset(reset), .Escribe(Escribe), .Lee(Lee),
        .Dir_segundo(Dir_segundo), .Dir_minuto(Dir_minuto), .Dir_hora(Dir_hora),
        .segundo(segundo), .minuto(minuto), .hora(hora), .AD_in(AD_in),
        .AD_out(AD_out), .AD_oe(AD_oe), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
        .A_D(A_D), .lect_seg(lect_seg), .lect_min(lect_min), .lect_hora(lect_hora),
        .T_Esc(T_Esc), .T_Lect(T_Lect)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected bus for cycle k after a start seen in cycle 0
    function automatic exp_t model(input int k, input bit wr,
                                   input logic [2:0][7:0] dir,
                                   input logic [2:0][7:0] dat);
        exp_t e;
        int j, p;
        e = '{cs_n:1, rd_n:1, wr_n:1, a_d:1, ad_oe:0, ad_out:0, t_esc:0, t_lect:0};
        if (k == KD) begin
            e.t_esc  = wr;
            e.t_lect = !wr;
            return e;
        end
        j = (k - 1) / L;
        p = (k - 1) % L;
        if (p < T) begin
            e.cs_n = 0; e.a_d = 0; e.wr_n = 0; e.ad_oe = 1; e.ad_out = dir[j];
        end else if (p > T && p <= 2 * T) begin
            e.cs_n = 0;
            if (wr) begin
                e.wr_n = 0; e.ad_oe = 1; e.ad_out = dat[j];
            end else begin
                e.rd_n = 0;
            end
        end
        return e;
    endfunction

    task automatic chk_bus(input string tag, input exp_t e);
        chk({tag, ".CS_n"},   32'(CS_n),   32'(e.cs_n));
        chk({tag, ".RD_n"},   32'(RD_n),   32'(e.rd_n));
        chk({tag, ".WR_n"},   32'(WR_n),   32'(e.wr_n));
        chk({tag, ".A_D"},    32'(A_D),    32'(e.a_d));
        chk({tag, ".AD_oe"},  32'(AD_oe),  32'(e.ad_oe));
        if (e.ad_oe) chk({tag, ".AD_out"}, 32'(AD_out), 32'(e.ad_out));
        chk({tag, ".T_Esc"},  32'(T_Esc),  32'(e.t_esc));
        chk({tag, ".T_Lect"}, 32'(T_Lect), 32'(e.t_lect));
        chk({tag, ".lect_seg"},  32'(lect_seg),  32'(m_lect[0]));
        chk({tag, ".lect_min"},  32'(lect_min),  32'(m_lect[1]));
        chk({tag, ".lect_hora"}, 32'(lect_hora), 32'(m_lect[2]));
    endtask

    function automatic exp_t idle_exp();
        return '{cs_n:1, rd_n:1, wr_n:1, a_d:1, ad_oe:0, ad_out:0, t_esc:0, t_lect:0};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; that cycle is cycle 0 (IDLE sampling requests)
    task automatic run_seq(input string tag, input bit esc, input bit lee, input bit hold,
                           input logic [2:0][7:0] dir, input logic [2:0][7:0] dat,
                           input logic [2:0][7:0] rdv, input int abort_k);
        int j, p;
        bit wr;
        wr = esc;
        Escribe = esc; Lee = lee;
        {Dir_hora, Dir_minuto, Dir_segundo} = dir;
        {hora, minuto, segundo} = dat;
        AD_in = 8'($urandom);
        @(negedge clk);
        chk_bus({tag, ".c0"}, idle_exp());
        for (int k = 1; k <= KD; k++) begin
            next_cycle();
            if (!hold) begin
                Escribe = (k < KD - 1) ? 1'($urandom) : 1'b0;
                Lee     = (k < KD - 1) ? 1'($urandom) : 1'b0;
            end
            Dir_segundo = 8'($urandom); Dir_minuto = 8'($urandom); Dir_hora = 8'($urandom);
            segundo = 8'($urandom); minuto = 8'($urandom); hora = 8'($urandom);
            j = (k - 1) / L;
            p = (k - 1) % L;
            AD_in = (k < KD && p > T && p <= 2 * T) ? rdv[j] : 8'($urandom);
            if (k == abort_k) reset = 1'b1;
            if (!wr && k < KD && p == 2 * T + 1) m_lect[j] = rdv[j];
            @(negedge clk);
            chk_bus($sformatf("%s.c%0d", tag, k), model(k, wr, dir, dat));
            if (k == abort_k) begin
                next_cycle();
                reset = 1'b0; Escribe = 1'b0; Lee = 1'b0;
                for (int i = 0; i < 3; i++) m_lect[i] = 8'h00;
                @(negedge clk);
                chk_bus({tag, ".abort"}, idle_exp());
                next_cycle();
                return;
            end
        end
        next_cycle();
    endtask

    logic [2:0][7:0] d_dir, d_dat, d_rd;

    initial begin
        for (int i = 0; i < 3; i++) m_lect[i] = 8'h00;
        reset = 1'b1; Escribe = 1'b0; Lee = 1'b0;
        Dir_segundo = 0; Dir_minuto = 0; Dir_hora = 0;
        segundo = 0; minuto = 0; hora = 0; AD_in = 0;
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk_bus("reset", idle_exp());

        // Idle with no requests
        for (int i = 0; i < 50; i++) begin
            next_cycle();
            @(negedge clk);
            chk_bus("idle", idle_exp());
        end
        next_cycle();

        // Directed write
        run_seq("wr_dir", 1'b1, 1'b0, 1'b0, {8'h23, 8'h22, 8'h21},
                {8'h12, 8'h45, 8'h30}, 24'h0, 0);

        // Directed read
        run_seq("rd_dir", 1'b0, 1'b1, 1'b0, {8'h43, 8'h42, 8'h41},
                {8'hAA, 8'hBB, 8'hCC}, {8'h02, 8'h10, 8'h05}, 0);
        chk("rd_dir.seg",  32'(lect_seg),  32'h05);
        chk("rd_dir.min",  32'(lect_min),  32'h10);
        chk("rd_dir.hora", 32'(lect_hora), 32'h02);

        // Both requests: write wins
        d_dir = 24'($urandom); d_dat = 24'($urandom);
        run_seq("both", 1'b1, 1'b1, 1'b0, d_dir, d_dat, 24'($urandom), 0);

        // Lee held: back-to-back reads with one IDLE cycle between
        d_dir = 24'($urandom); d_rd = 24'($urandom);
        run_seq("b2b_0", 1'b0, 1'b1, 1'b1, d_dir, 24'($urandom), d_rd, 0);
        d_dir = 24'($urandom); d_rd = 24'($urandom);
        run_seq("b2b_1", 1'b0, 1'b1, 1'b0, d_dir, 24'($urandom), d_rd, 0);

        // Reset during minuto DATA phase, then quiet, then restart from segundo
        run_seq("abort", 1'b0, 1'b1, 1'b1, 24'($urandom), 24'($urandom), 24'($urandom), L + T + 3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk_bus("post_abort", idle_exp());
            next_cycle();
        end
        run_seq("restart", 1'b0, 1'b1, 1'b0, 24'($urandom), 24'($urandom), 24'($urandom), 0);

        // Random mix
        for (int n = 0; n < 6; n++) begin
            bit e;
            e = 1'($urandom);
            run_seq($sformatf("rnd%0d", n), e, !e | 1'($urandom), 1'b0,
                    24'($urandom), 24'($urandom), 24'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
